pagerank_work_dispatcher: RTL

Upstream feeder for the pageRank Top core.
- Accepts one job command (start page, total pages, chunk size).
- Splits the job into chunked requests on the core's io_in channel, then sends a terminating done packet.
- Consumes one io_out result per chunk, accumulates the results, and pulses job_done when the job is complete.
- Replaces the fixed single-request stimulus with a bounded-outstanding request stream.

---
 rtl/pagerank_work_dispatcher_if.sv | 41 ++++
 rtl/pagerank_work_dispatcher.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pagerank_work_dispatcher_if.sv
// Handshake bundle between the job source, the pageRank core and the work dispatcher.
// Every channel transfers on a rising clk edge where valid && ready; a raised valid holds its payload until taken.
interface pagerank_work_dispatcher_if #(
    parameter int ID_W  = 32,
    parameter int LEN_W = 32,
    parameter int OUT_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [ID_W-1:0]  cmd_start_id;
    logic [LEN_W-1:0] cmd_total;
    logic [LEN_W-1:0] cmd_chunk;

    logic             io_in_valid;
    logic             io_in_ready;
    logic             io_in_bits_done;
    logic [ID_W-1:0]  io_in_bits_startPageId;
    logic [LEN_W-1:0] io_in_bits_length;

    logic             io_out_valid;
    logic             io_out_ready;
    logic [OUT_W-1:0] io_out_bits_out;

    modport master (
        input  cmd_valid, cmd_start_id, cmd_total, cmd_chunk,
        output cmd_ready,
        output io_in_valid, io_in_bits_done, io_in_bits_startPageId, io_in_bits_length,
        input  io_in_ready,
        input  io_out_valid, io_out_bits_out,
        output io_out_ready
    );

    modport slave (
        output cmd_valid, cmd_start_id, cmd_total, cmd_chunk,
        input  cmd_ready,
        input  io_in_valid, io_in_bits_done, io_in_bits_startPageId, io_in_bits_length,
        output io_in_ready,
        output io_out_valid, io_out_bits_out,
        input  io_out_ready
    );
endinterface

// File: rtl/pagerank_work_dispatcher.sv
// Splits one job into chunked page requests for the pageRank core and sums the results.
// Optional stall counter output enabled by defining PAGERANK_DISP_STALL_CNT_EN.
module pagerank_work_dispatcher #(
    parameter int ID_W    = 32,
    parameter int LEN_W   = 32,
    parameter int OUT_W   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    pagerank_work_dispatcher_if.master     bus,
    output logic                           busy,
    output logic                           job_done,
    output logic [OUT_W-1:0]               result_sum,
    output logic [LEN_W-1:0]               chunks_sent,
`ifdef PAGERANK_DISP_STALL_CNT_EN
    output logic [LEN_W-1:0]               stall_cycles,
`endif
    output logic [2:0]                     dbg_state
);
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_FLUSH  = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    next_id_q, next_id_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [LEN_W-1:0]   chunk_q, chunk_d;
    logic [OUT_W-1:0]   result_sum_q, result_sum_d;
    logic [LEN_W-1:0]   chunks_sent_q, chunks_sent_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
`ifdef PAGERANK_DISP_STALL_CNT_EN
    logic [LEN_W-1:0]   stall_q, stall_d;
`endif

    logic               can_issue;
    logic [LEN_W-1:0]   chunk_len;
    logic               in_fire;
    logic               out_fire;
    logic               issue_fire;

    // Request payload is a pure function of registered state, so it stays put while stalled.
    assign can_issue  = (outstanding_q < CNT_W'(MAX_OUT));
    assign chunk_len  = (remaining_q < chunk_q) ? remaining_q : chunk_q;

    assign bus.cmd_ready              = (state_q == S_IDLE);
    assign bus.io_in_valid            = ((state_q == S_ISSUE) && can_issue) || (state_q == S_FLUSH);
    assign bus.io_in_bits_done        = (state_q == S_FLUSH);
    assign bus.io_in_bits_startPageId = (state_q == S_ISSUE) ? next_id_q : '0;
    assign bus.io_in_bits_length      = (state_q == S_ISSUE) ? chunk_len : '0;
    assign bus.io_out_ready           = (state_q == S_ISSUE) || (state_q == S_DRAIN) ||
                                        (state_q == S_FLUSH);

    assign in_fire    = bus.io_in_valid && bus.io_in_ready;
    assign out_fire   = bus.io_out_valid && bus.io_out_ready;
    assign issue_fire = in_fire && (state_q == S_ISSUE);

    assign busy        = (state_q != S_IDLE);
    assign job_done    = (state_q == S_FINISH);
    assign result_sum  = result_sum_q;
    assign chunks_sent = chunks_sent_q;
    assign dbg_state   = state_q;
`ifdef PAGERANK_DISP_STALL_CNT_EN
    assign stall_cycles = stall_q;
`endif

    always_comb begin
        state_d       = state_q;
        next_id_d     = next_id_q;
        remaining_d   = remaining_q;
        chunk_d       = chunk_q;
        result_sum_d  = result_sum_q;
        chunks_sent_d = chunks_sent_q;
        outstanding_d = outstanding_q;
`ifdef PAGERANK_DISP_STALL_CNT_EN
        stall_d       = stall_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    next_id_d     = bus.cmd_start_id;
                    remaining_d   = bus.cmd_total;
                    chunk_d       = (bus.cmd_chunk == '0) ? LEN_W'(1) : bus.cmd_chunk;
                    result_sum_d  = '0;
                    chunks_sent_d = '0;
                    outstanding_d = '0;
`ifdef PAGERANK_DISP_STALL_CNT_EN
                    stall_d       = '0;
`endif
                    state_d       = (bus.cmd_total == '0) ? S_FLUSH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (in_fire) begin
                    next_id_d     = next_id_q + ID_W'(chunk_len);
                    remaining_d   = remaining_q - chunk_len;
                    chunks_sent_d = chunks_sent_q + LEN_W'(1);
                    if (remaining_q == chunk_len) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (in_fire) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (out_fire) begin
            result_sum_d = result_sum_q + bus.io_out_bits_out;
        end

        // A result arriving with nothing outstanding is still summed; the count floors at zero.
        if (issue_fire && !out_fire) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (out_fire && !issue_fire && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

`ifdef PAGERANK_DISP_STALL_CNT_EN
        if (bus.io_in_valid && !bus.io_in_ready && (stall_q != '1)) begin
            stall_d = stall_q + LEN_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            next_id_q     <= '0;
            remaining_q   <= '0;
            chunk_q       <= '0;
            result_sum_q  <= '0;
            chunks_sent_q <= '0;
            outstanding_q <= '0;
`ifdef PAGERANK_DISP_STALL_CNT_EN
            stall_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            next_id_q     <= next_id_d;
            remaining_q   <= remaining_d;
            chunk_q       <= chunk_d;
            result_sum_q  <= result_sum_d;
            chunks_sent_q <= chunks_sent_d;
            outstanding_q <= outstanding_d;
`ifdef PAGERANK_DISP_STALL_CNT_EN
            stall_q       <= stall_d;
`endif
        end
    end
endmodule
